// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared FSM encoding, default dividers and width helper for the X/Y scan arbiter
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    LOAD   = 3'd2,
    SETTLE = 3'd3,
    ON     = 3'd4
  } state_t;

  // Defaults assume a 100 MHz sysclk: 5 kHz scan slots, 500 Hz game ticks, 1 us settle.
  localparam int DEF_SCAN_DIV   = 20000;
  localparam int DEF_CTR_DIV    = 200000;
  localparam int DEF_SETTLE_CYC = 100;

  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/tick_div.sv
// rtl/tick_div.sv - prescaler producing a one-cycle tick every DIV enabled cycles
module tick_div
  import scan_pkg::*;
#(
  parameter int DIV = DEF_SCAN_DIV
) (
  input  logic sysclk,
  input  logic sys_rst_n,
  input  logic en,
  output logic tick
);

  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (!en || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/xy_scan_arbiter.sv
// rtl/xy_scan_arbiter.sv - round-robin time-slot scheduler for the shared beam X/Y DAC with settle-delayed unblank
module xy_scan_arbiter
  import scan_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int COORD_W    = 8,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int CTR_DIV    = DEF_CTR_DIV,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                       sysclk,
  input  logic                       sys_rst_n,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*COORD_W-1:0]   req_x,
  input  logic [N_REQ*COORD_W-1:0]   req_y,
  output logic [N_REQ-1:0]           grant,
  output logic [COORD_W-1:0]         dac_x,
  output logic [COORD_W-1:0]         dac_y,
  output logic                       z_on,
  output logic                       scan_tick,
  output logic                       ctr_tick
);

  localparam int PTR_W = cnt_w(N_REQ);
  localparam int SET_W = cnt_w(SETTLE_CYC);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
  // The LOAD cycle is the first settle cycle, so SETTLE itself lasts SETTLE_CYC-1 cycles.
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYC >= 2) ? SETTLE_CYC - 2 : 0);

  state_t               state, state_n;
  logic [PTR_W-1:0]     ptr, ptr_n, cand, hit_idx;
  logic                 hit;
  logic [N_REQ-1:0]     grant_n;
  logic [COORD_W-1:0]   dac_x_n, dac_y_n;
  logic                 z_on_n;
  logic [SET_W-1:0]     settle_cnt, settle_cnt_n;
  logic [COORD_W-1:0]   xs [N_REQ];
  logic [COORD_W-1:0]   ys [N_REQ];

  tick_div #(.DIV(SCAN_DIV)) u_scan_div (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .tick      (scan_tick)
  );

  tick_div #(.DIV(CTR_DIV)) u_ctr_div (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .tick      (ctr_tick)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      xs[i] = req_x[i*COORD_W +: COORD_W];
      ys[i] = req_y[i*COORD_W +: COORD_W];
    end
  end

  // Search starts one past the last winner; wrap is a compare so N_REQ need not be a power of 2.
  always_comb begin
    hit     = 1'b0;
    hit_idx = ptr;
    cand    = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == PTR_LAST) ? '0 : cand + 1'b1;
      if (!hit && req[cand]) begin
        hit     = 1'b1;
        hit_idx = cand;
      end
    end
  end

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    grant_n      = '0;
    dac_x_n      = dac_x;
    dac_y_n      = dac_y;
    z_on_n       = 1'b0;
    settle_cnt_n = settle_cnt;
    if (!en) begin
      state_n      = IDLE;
      settle_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_tick) state_n = ARB;
        end
        ARB: begin
          if (hit) begin
            state_n          = LOAD;
            ptr_n            = hit_idx;
            grant_n[hit_idx] = 1'b1;
            dac_x_n          = xs[hit_idx];
            dac_y_n          = ys[hit_idx];
            z_on_n           = (SETTLE_CYC == 0);
          end else begin
            state_n = IDLE;
          end
        end
        LOAD: begin
          settle_cnt_n = '0;
          if (SETTLE_CYC <= 1) begin
            state_n = ON;
            z_on_n  = 1'b1;
          end else begin
            state_n = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_n = ON;
            z_on_n  = 1'b1;
          end else begin
            settle_cnt_n = settle_cnt + 1'b1;
          end
        end
        ON: begin
          // Blank on the tick itself so the beam is dark before the DAC moves.
          if (scan_tick) state_n = ARB;
          else           z_on_n  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      ptr        <= PTR_LAST;
      grant      <= '0;
      dac_x      <= '0;
      dac_y      <= '0;
      z_on       <= 1'b0;
      settle_cnt <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      grant      <= grant_n;
      dac_x      <= dac_x_n;
      dac_y      <= dac_y_n;
      z_on       <= z_on_n;
      settle_cnt <= settle_cnt_n;
    end
  end

endmodule

// File: tb/tb_xy_scan_arbiter.sv
// tb/tb_xy_scan_arbiter.sv - directed scoreboard bench for xy_scan_arbiter (SCAN_DIV=16, CTR_DIV=64, SETTLE_CYC=3)
module tb_xy_scan_arbiter;

  typedef struct {
    logic [3:0] g;
    logic [7:0] x;
    logic [7:0] y;
  } exp_t;

  logic        sysclk = 1'b0;
  logic        sys_rst_n;
  logic        en;
  logic [3:0]  req;
  logic [7:0]  bx [4];
  logic [7:0]  by [4];
  logic [31:0] req_x, req_y;
  logic [3:0]  grant;
  logic [7:0]  dac_x, dac_y;
  logic        z_on, scan_tick, ctr_tick;

  int   checks = 0;
  int   passes = 0;
  exp_t sb [$];
  exp_t mon_e;

  assign req_x = {bx[3], bx[2], bx[1], bx[0]};
  assign req_y = {by[3], by[2], by[1], by[0]};

  always #5 sysclk = ~sysclk;

  xy_scan_arbiter #(
    .N_REQ(4), .COORD_W(8), .SCAN_DIV(16), .CTR_DIV(64), .SETTLE_CYC(3)
  ) dut (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .grant     (grant),
    .dac_x     (dac_x),
    .dac_y     (dac_y),
    .z_on      (z_on),
    .scan_tick (scan_tick),
    .ctr_tick  (ctr_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nc(input int k);
    repeat (k) @(negedge sysclk);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge sysclk);
    while (scan_tick !== 1'b1 && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    if (scan_tick !== 1'b1) chk("tick_timeout", {31'd0, scan_tick}, 32'd1);
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.g = g;
    e.x = x;
    e.y = y;
    sb.push_back(e);
  endtask

  // Every grant pulse must match the oldest expected slot.
  always @(negedge sysclk) begin
    if (sys_rst_n === 1'b1 && grant !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_grant", grant, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_grant", grant, mon_e.g);
        chk("sb_dac_x", dac_x, mon_e.x);
        chk("sb_dac_y", dac_y, mon_e.y);
      end
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    en  = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      bx[i] = 8'h00;
      by[i] = 8'h00;
    end
    nc(2);
    chk("rst_grant", grant, 0);
    chk("rst_dac_x", dac_x, 0);
    chk("rst_dac_y", dac_y, 0);
    chk("rst_z_on", z_on, 0);
    chk("rst_scan_tick", scan_tick, 0);
    chk("rst_ctr_tick", ctr_tick, 0);
    sys_rst_n = 1'b1;

    // 1: idle ticking with no requesters
    for (int i = 1; i <= 70; i++) begin
      nc(1);
      chk("t1_scan_tick", scan_tick, (i % 16 == 15) ? 1 : 0);
      chk("t1_ctr_tick", ctr_tick, (i % 64 == 63) ? 1 : 0);
      chk("t1_grant", grant, 0);
      chk("t1_z_on", z_on, 0);
    end

    // 2: single requester latency and blanking
    req = 4'b0001; bx[0] = 8'h40; by[0] = 8'h80;
    push(4'b0001, 8'h40, 8'h80);
    wait_tick();
    nc(1); chk("t2_grant_t1", grant, 0);
    nc(1); chk("t2_grant_t2", grant, 4'b0001);
    chk("t2_dac_x", dac_x, 8'h40);
    chk("t2_dac_y", dac_y, 8'h80);
    chk("t2_z_t2", z_on, 0);
    req = 4'b0000;
    nc(1); chk("t2_grant_pulse", grant, 0); chk("t2_z_t3", z_on, 0);
    nc(1); chk("t2_z_t4", z_on, 0);
    nc(1); chk("t2_z_t5", z_on, 1);
    wait_tick(); chk("t2_z_at_tick", z_on, 1);
    nc(1); chk("t2_z_fall", z_on, 0);
    nc(1); chk("t2_no_grant", grant, 0);

    // 3: full round robin from reset pointer
    @(negedge sysclk); sys_rst_n = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bx[i] = 8'hA0 + 8'(i);
      by[i] = 8'h50 + 8'(i);
    end
    for (int s = 0; s < 8; s++) push(4'(1 << (s % 4)), 8'hA0 + 8'(s % 4), 8'h50 + 8'(s % 4));
    @(negedge sysclk); sys_rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      wait_tick();
      nc(2);
      chk("t3_rr_grant", grant, 32'(1) << (s % 4));
      chk("t3_rr_dac_x", dac_x, 8'hA0 + 8'(s % 4));
    end
    req = 4'b0010;
    push(4'b0010, 8'hA1, 8'h51);
    wait_tick(); nc(2); chk("t4_ptr_setup", grant, 4'b0010);

    // 4: sparse requesters from ptr=1
    req = 4'b1010;
    push(4'b1000, 8'hA3, 8'h53);
    push(4'b0010, 8'hA1, 8'h51);
    push(4'b1000, 8'hA3, 8'h53);
    for (int s = 0; s < 3; s++) begin
      wait_tick(); nc(2);
      chk("t4_sparse_grant", grant, (s % 2 == 0) ? 32'h8 : 32'h2);
    end

    // 5: coordinate change after LOAD does not affect the slot
    req = 4'b0010; bx[1] = 8'h10; by[1] = 8'h33;
    push(4'b0010, 8'h10, 8'h33);
    wait_tick(); nc(2);
    chk("t5_grant", grant, 4'b0010); chk("t5_dac_x", dac_x, 8'h10);
    nc(1); bx[1] = 8'h20;
    push(4'b0010, 8'h20, 8'h33);
    nc(1); chk("t5_hold_t4", dac_x, 8'h10);
    nc(1); chk("t5_hold_t5", dac_x, 8'h10); chk("t5_z_on", z_on, 1);
    wait_tick(); chk("t5_hold_tick", dac_x, 8'h10);
    nc(2); chk("t5_regrant", grant, 4'b0010); chk("t5_new_x", dac_x, 8'h20);
    nc(1); req = 4'b0000;
    nc(2); chk("t5_drop_z5", z_on, 1);
    nc(5); chk("t5_drop_z10", z_on, 1);

    // 6: disable during ON, then async reset during SETTLE
    en = 1'b0;
    nc(1); chk("t6_en_z", z_on, 0); chk("t6_en_grant", grant, 0);
    for (int i = 0; i < 20; i++) begin
      nc(1);
      chk("t6_off_scan", scan_tick, 0);
      chk("t6_off_ctr", ctr_tick, 0);
      chk("t6_off_dac", dac_x, 8'h20);
    end
    req = 4'b0001; bx[0] = 8'h55; by[0] = 8'h66;
    push(4'b0001, 8'h55, 8'h66);
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      nc(1);
      chk("t6_reen_scan", scan_tick, (i == 15) ? 1 : 0);
    end
    nc(1); chk("t6_reen_grant", grant, 4'b0001); chk("t6_reen_dac_y", dac_y, 8'h66);
    nc(1);
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_z", z_on, 0);
    chk("t6_rst_dac_x", dac_x, 0);
    chk("t6_rst_grant", grant, 0);
    nc(1);
    sys_rst_n = 1'b1;
    req = 4'b0101;
    push(4'b0001, 8'h55, 8'h66);
    wait_tick(); nc(2);
    chk("t6_rst_first_grant", grant, 4'b0001);
    req = 4'b0000;
    nc(20);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
